// File: rtl/axi_mem_arbiter.sv
// Arbitrates CPU instruction fetch and data accesses onto one AXI3 master port.
// Fetch misses fill an internal line buffer with an INCR burst; data accesses are single beats.
module axi_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_en,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  input  logic                  data_en,
  input  logic [3:0]            data_wen,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  stall_all,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ID_WIDTH-1:0]   awid,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int LW  = $clog2(BURST_LEN);
  localparam int OFF = LW + 2;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~(ADDR_WIDTH'((1 << OFF) - 1));
  localparam logic [LW-1:0]         CNT_LAST   = LW'(BURST_LEN - 1);
  localparam logic [3:0]            ARLEN_LINE = 4'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_RADDR = 3'd1,
    I_RDATA = 3'd2,
    D_RADDR = 3'd3,
    D_RDATA = 3'd4,
    WR_ADDR = 3'd5,
    WR_RESP = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    valid_r;
  logic [ADDR_WIDTH-1:0]   tag_r;
  logic [LW-1:0]           cnt_r;
  logic                    aw_done_r;
  logic                    w_done_r;
  logic [DATA_WIDTH-1:0]   data_rdata_r;
  logic [DATA_WIDTH-1:0]   buf_r [BURST_LEN];
  logic [ADDR_WIDTH-1:0]   inst_line_s;
  logic [ADDR_WIDTH-1:0]   data_line_s;
  logic                    hit_s;

  assign inst_line_s = inst_addr & LINE_MASK;
  assign data_line_s = data_addr & LINE_MASK;
  assign hit_s       = valid_r && (tag_r == inst_line_s);
  assign inst_rdata  = buf_r[inst_addr[OFF-1:2]];
  assign data_rdata  = data_rdata_r;
  // DONE hands the data result back, so the data request stops stalling there.
  assign stall_all   = (data_en && (state_r != DONE)) || (inst_en && !hit_s);

  assign arid    = {ID_WIDTH{1'b0}};
  assign awid    = {ID_WIDTH{1'b0}};
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign awaddr  = data_addr;
  assign awlen   = 4'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wdata   = data_wdata;
  assign wstrb   = data_wen;
  assign wlast   = 1'b1;

  // Next-state decode; the data port takes priority over fetch in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (data_en && (data_wen != 4'b0000)) begin
          state_nxt_s = WR_ADDR;
        end else if (data_en) begin
          state_nxt_s = D_RADDR;
        end else if (inst_en && !hit_s) begin
          state_nxt_s = I_RADDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      I_RADDR: state_nxt_s = arready ? I_RDATA : I_RADDR;
      I_RDATA: state_nxt_s = (rvalid && rlast) ? IDLE : I_RDATA;
      D_RADDR: state_nxt_s = arready ? D_RDATA : D_RADDR;
      D_RDATA: state_nxt_s = rvalid ? DONE : D_RDATA;
      WR_ADDR: begin
        if ((aw_done_r || awready) && (w_done_r || wready)) begin
          state_nxt_s = WR_RESP;
        end else begin
          state_nxt_s = WR_ADDR;
        end
      end
      WR_RESP: state_nxt_s = bvalid ? DONE : WR_RESP;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // AXI valid/ready and read address decode from the current state.
  always_comb begin
    arvalid = 1'b0;
    araddr  = {ADDR_WIDTH{1'b0}};
    arlen   = 4'd0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (state_r)
      I_RADDR: begin
        arvalid = 1'b1;
        araddr  = tag_r;
        arlen   = ARLEN_LINE;
      end
      I_RDATA: rready = 1'b1;
      D_RADDR: begin
        arvalid = 1'b1;
        araddr  = data_addr;
      end
      D_RDATA: rready = 1'b1;
      WR_ADDR: begin
        awvalid = !aw_done_r;
        wvalid  = !w_done_r;
      end
      WR_RESP: bready = 1'b1;
      default: arvalid = 1'b0;
    endcase
  end

  // State, line tag/valid, beat counter, write-channel completion and load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      valid_r      <= 1'b0;
      tag_r        <= {ADDR_WIDTH{1'b0}};
      cnt_r        <= {LW{1'b0}};
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
      data_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (state_nxt_s == I_RADDR) begin
            tag_r   <= inst_line_s;
            valid_r <= 1'b0;
          end else if ((state_nxt_s == WR_ADDR) && (data_line_s == tag_r)) begin
            valid_r <= 1'b0;
          end
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end
        I_RADDR: cnt_r <= {LW{1'b0}};
        I_RDATA: begin
          if (rvalid) begin
            cnt_r <= cnt_r + 1'b1;
            // A short burst leaves the line invalid so the fetch retries it.
            if (rlast) begin
              valid_r <= (cnt_r == CNT_LAST);
            end
          end
        end
        D_RDATA: begin
          if (rvalid) begin
            data_rdata_r <= rdata;
          end
        end
        WR_ADDR: begin
          if (awready) begin
            aw_done_r <= 1'b1;
          end
          if (wready) begin
            w_done_r <= 1'b1;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Line storage; contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    if ((state_r == I_RDATA) && rvalid) begin
      buf_r[cnt_r] <= rdata;
    end
  end

endmodule
